dig_scan_ctrl: RTL and testbench
================================

// Module: dig_scan_ctrl
// PURPOSE
// - Memory-mapped controller for the 8-digit 7-segment display on the peripheral side of Bridge.
// - Sits on the Bridge rst/clk/addr/wen/wdata_to_dig interface and latches CPU writes into a data register and a control register.
// - Time-multiplexes the digits through a prescaler, digit counter and BLANK/DRIVE FSM.
// - Drives dig_en and DN_A..DN_DP at the SoC top level.
// PARAMETERS
// - NUM_DIGITS  8      number of digits scanned; one hex nibble each.
// - SCAN_DIV    25000  clk cycles per digit slot; 1 ms at 25 MHz.
// - BLANK_CYC   250    cycles at the start of each slot with all digits off (anti-ghosting).
//   Constraint: 0 < BLANK_CYC < SCAN_DIV.
// PORTS
// - clk       in   1   CPU clock, from clk_to_dig.
// - rst_n     in   1   Reset, asynchronous, active-low.
// - addr      in   32  Bus address; only addr[2] is decoded (0 = DATA, 1 = CTRL).
// - wen       in   1   Write enable; the write lands at posedge clk.
// - wdata     in   32  Write data.
// - dig_en_n  out  8   Digit enables, active-low; bit i = digit i (rightmost = 0).
// - seg_n     out  8   Segments, active-low: {DP,G,F,E,D,C,B,A}, mapped to DN_DP..DN_A.
// BEHAVIOUR
// - Reset (async, immediate, also mid-slot):
//   - DATA = 0; CTRL.en_mask[7:0] = 8'hFF; CTRL.dp_mask[15:8] = 8'h00.
//   - cnt = 0, idx = 0, state = BLANK.
//   - dig_en_n = 8'hFF, seg_n = 8'hFF.
// - Register writes:
//   - wen & !addr[2] -> DATA <= wdata.
//   - wen & addr[2] -> CTRL <= wdata[15:0]; wdata[31:16] is ignored.
//   - The register is readable by the datapath on the next cycle. No read port: this is a write-only device.
// - Prescaler:
//   - cnt counts 0..SCAN_DIV-1.
//   - At cnt == SCAN_DIV-1: cnt <= 0 and idx <= (idx == NUM_DIGITS-1) ? 0 : idx+1 (wrap).
// - FSM, decoded from cnt:
//   - BLANK while cnt < BLANK_CYC.
//   - DRIVE while cnt >= BLANK_CYC.
//   - Transitions: BLANK -> DRIVE at cnt == BLANK_CYC; DRIVE -> BLANK at slot rollover.
// - Outputs are registered and lag cnt/idx/registers by exactly 1 cycle.
//   - BLANK, or en_mask[idx] == 0 -> dig_en_n = 8'hFF, seg_n = 8'hFF.
//   - DRIVE and en_mask[idx] == 1 -> dig_en_n = ~(8'b1 << idx).
//   - DRIVE and en_mask[idx] == 1 -> seg_n = ~{dp_mask[idx], hex7(DATA[4*idx+3 -: 4])}.
// - Glitch rule: at most one dig_en_n bit is low in any cycle. No cycle ever has two digits on, including at rollover.
// - Write during DRIVE: the new digit pattern appears 2 cycles after the write edge (register, then output flop). The slot is not restarted.
// - Simultaneous write and slot rollover: both take effect; the new slot uses the new register value.
// - hex7 table, active-high {G..A}:
//   - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
//   - 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71
// STRUCTURE
// - Shared package dig_pkg:
//   - Register offsets DIG_DATA_OFS = 0, DIG_CTRL_OFS = 4.
//   - CTRL field positions.
//   - FSM state enum {ST_BLANK, ST_DRIVE}.
//   - 16-entry hex7 constant table.
// - One sub-module: hex7seg, a combinational 4-bit -> 7-bit active-high decoder.
// - Top of block: prescaler, idx counter, FSM, registers, output flops.
// - Instantiated in miniRV_SoC on the Bridge *_to_dig signals.
// TESTING (bench uses SCAN_DIV = 8, BLANK_CYC = 2, NUM_DIGITS = 8)
// 1. Hold rst_n = 0 -> dig_en_n = FF, seg_n = FF. Release, DATA = 0 -> FF for 2 edges; after 3rd edge dig_en_n = FE, seg_n = C0 ('0').
// 2. Write DATA = 0x12345678 -> slot0 seg_n = 80 ('8'); slot7 dig_en_n = 7F, seg_n = F9 ('1').
// 3. Write CTRL = 0x0000_000F -> slots 4-7 keep dig_en_n = FF, seg_n = FF; slots 0-3 are driven normally.
// 4. Write CTRL = 0x0000_08FF, DATA = 0 -> slot3 seg_n = 40 (DP on); all other slots seg_n = C0.
// 5. Run 64+ cycles -> idx wraps 7 -> 0. Assert on every cycle that popcount(~dig_en_n) <= 1 and that each slot starts with 2 blank cycles.
// 6. Drop rst_n mid-DRIVE in slot 5 -> outputs go to FF in the same cycle (async) and DATA clears. After release, scanning restarts at slot 0 and shows '0'.

Source files
------------

// File: rtl/dig_pkg.sv
// Shared definitions for the 7-segment scan controller: register map, CTRL
// field layout, FSM state codes and the hex-to-segment glyph table.
package dig_pkg;

    localparam logic [31:0] DIG_DATA_OFS = 32'h0000_0000;
    localparam logic [31:0] DIG_CTRL_OFS = 32'h0000_0004;

    // CTRL layout: en_mask in [7:0], dp_mask in [15:8]
    localparam int          CTRL_EN_LSB  = 0;
    localparam int          CTRL_DP_LSB  = 8;
    localparam int          CTRL_FIELD_W = 8;
    localparam logic [15:0] CTRL_RESET   = 16'h00FF;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    // Active-high {G,F,E,D,C,B,A}; entry 0 is the rightmost element
    localparam logic [15:0][6:0] HEX7_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/hex7seg.sv
// Combinational 4-bit hex digit to 7-segment decoder, active-high {G..A}.
module hex7seg
    import dig_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX7_TABLE[nibble];

endmodule

// File: rtl/dig_scan_ctrl.sv
// Write-only memory-mapped 8-digit 7-segment scan controller: DATA/CTRL
// registers, slot prescaler, digit index, BLANK/DRIVE FSM and output flops.
module dig_scan_ctrl
    import dig_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 25000,
    parameter int BLANK_CYC  = 250
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           addr,
    input  logic                  wen,
    input  logic [31:0]           wdata,
    output logic [NUM_DIGITS-1:0] dig_en_n,
    output logic [7:0]            seg_n,
    output logic [0:0]            dbg_state
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0]         CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]         CNT_BLANK = CW'(BLANK_CYC);
    localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_ONE   = NUM_DIGITS'(1);

    logic [31:0]             data_q;
    logic [15:0]             ctrl_q;
    logic [CW-1:0]           cnt_q;
    logic [CW-1:0]           cnt_d;
    logic [IW-1:0]           idx_q;
    logic [0:0]              state_q;
    logic                    slot_end;
    logic [CTRL_FIELD_W-1:0] en_mask;
    logic [CTRL_FIELD_W-1:0] dp_mask;
    logic [3:0]              nibble;
    logic [6:0]              glyph;
    logic                    unused_bits;

    // Only addr[2] selects the register; the rest of the bus is don't-care.
    assign unused_bits = ^{addr[31:3], addr[1:0], wdata[31:16]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            ctrl_q <= CTRL_RESET;
        end else if (wen) begin
            if (addr[2]) ctrl_q <= wdata[15:0];
            else         data_q <= wdata;
        end
    end

    assign slot_end = (cnt_q == CNT_LAST);
    assign cnt_d    = slot_end ? '0 : cnt_q + CW'(1);

    // state_q is decoded from the next count so it always matches cnt_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= ST_BLANK;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= (cnt_d < CNT_BLANK) ? ST_BLANK : ST_DRIVE;
            if (slot_end) idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
    end

    assign en_mask   = ctrl_q[CTRL_EN_LSB +: CTRL_FIELD_W];
    assign dp_mask   = ctrl_q[CTRL_DP_LSB +: CTRL_FIELD_W];
    assign nibble    = data_q[{idx_q, 2'b00} +: 4];
    assign dbg_state = state_q;

    hex7seg u_hex7seg (
        .nibble (nibble),
        .seg    (glyph)
    );

    // Both outputs come from one flop stage, so at most one digit is ever on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_en_n <= '1;
            seg_n    <= '1;
        end else if (state_q == ST_DRIVE && en_mask[idx_q]) begin
            dig_en_n <= ~(DIG_ONE << idx_q);
            seg_n    <= ~{dp_mask[idx_q], glyph};
        end else begin
            dig_en_n <= '1;
            seg_n    <= '1;
        end
    end

endmodule

// File: tb/tb_dig_scan_ctrl.sv
// Self-checking bench for dig_scan_ctrl: directed vector table, hand-written
// multi-cycle sequences and random bus writes against a slot/phase model.
module tb_dig_scan_ctrl;
    import dig_pkg::*;

    localparam int NUM_DIGITS = 8;
    localparam int SCAN_DIV   = 8;
    localparam int BLANK_CYC  = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [7:0]  dig_en_n;
    logic [7:0]  seg_n;
    logic [0:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: edges since reset release plus shadow registers
    int          t;
    logic [31:0] m_data;
    logic [15:0] m_ctrl;
    logic [6:0]  hex_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        logic [15:0] ctrl;
        logic [31:0] data;
        int          slot;
        logic [7:0]  exp_de;
        logic [7:0]  exp_seg;
    } vec_t;
    vec_t vecs [14];

    dig_scan_ctrl #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .BLANK_CYC  (BLANK_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (addr),
        .wen       (wen),
        .wdata     (wdata),
        .dig_en_n  (dig_en_n),
        .seg_n     (seg_n),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0d)", name, act, exp, t);
        end
    endtask

    // Output after the edge that consumes model time t: slot = t/DIV, phase = t%DIV
    function automatic void model_out(output logic [7:0] de, output logic [7:0] sg);
        int         ph;
        int         sl;
        logic [3:0] nib;
        ph = t % SCAN_DIV;
        sl = (t / SCAN_DIV) % NUM_DIGITS;
        de = 8'hFF;
        sg = 8'hFF;
        if (ph >= BLANK_CYC && m_ctrl[sl]) begin
            de[sl] = 1'b0;
            nib    = m_data[4*sl +: 4];
            sg     = ~{m_ctrl[8+sl], hex_ref[nib]};
        end
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        wen   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        t      = 0;
        m_data = 32'h0;
        m_ctrl = 16'h00FF;
    endtask

    // One clock: drive bus, advance model, compare outputs and state
    task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic [7:0] ede;
        logic [7:0] esg;
        logic [0:0] est;
        wen   = w;
        addr  = a;
        wdata = d;
        model_out(ede, esg);
        @(posedge clk);
        if (w) begin
            if (a[2]) m_ctrl = d[15:0];
            else      m_data = d;
        end
        t++;
        #1;
        wen = 1'b0;
        est = ((t % SCAN_DIV) < BLANK_CYC) ? ST_BLANK : ST_DRIVE;
        check("model_dig_en_n", dig_en_n, ede);
        check("model_seg_n", seg_n, esg);
        check("model_state", dbg_state, est);
        check("one_digit_on", ($countones(~dig_en_n) <= 1), 1);
    endtask

    task automatic run_to(input int target);
        while (t < target) step(1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        wen   = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        t     = 0;

        vecs[0]  = '{16'h00FF, 32'h1234_5678, 0, 8'hFE, 8'h80};
        vecs[1]  = '{16'h00FF, 32'h1234_5678, 7, 8'h7F, 8'hF9};
        vecs[2]  = '{16'h000F, 32'h1234_5678, 4, 8'hFF, 8'hFF};
        vecs[3]  = '{16'h000F, 32'h1234_5678, 3, 8'hF7, 8'h92};
        vecs[4]  = '{16'h000F, 32'h1234_5678, 7, 8'hFF, 8'hFF};
        vecs[5]  = '{16'h08FF, 32'h0000_0000, 3, 8'hF7, 8'h40};
        vecs[6]  = '{16'h08FF, 32'h0000_0000, 2, 8'hFB, 8'hC0};
        vecs[7]  = '{16'h00FF, 32'hFEDC_BA90, 1, 8'hFD, 8'h90};
        vecs[8]  = '{16'h00FF, 32'hFEDC_BA90, 7, 8'h7F, 8'h8E};
        vecs[9]  = '{16'h00FF, 32'hFEDC_BA90, 5, 8'hDF, 8'hA1};
        vecs[10] = '{16'hFFFF, 32'hFEDC_BA90, 0, 8'hFE, 8'h40};
        vecs[11] = '{16'h40FF, 32'hFEDC_BA90, 6, 8'hBF, 8'h06};
        vecs[12] = '{16'h00A5, 32'h0000_ABCD, 2, 8'hFB, 8'h83};
        vecs[13] = '{16'h00A5, 32'h0000_ABCD, 1, 8'hFF, 8'hFF};

        // Reset values and first-slot latency
        repeat (2) @(posedge clk);
        #1;
        check("reset_dig_en_n", dig_en_n, 8'hFF);
        check("reset_seg_n", seg_n, 8'hFF);
        check("reset_state", dbg_state, ST_BLANK);
        do_reset();
        step(1'b0, 32'h0, 32'h0);
        check("edge1_dig_en_n", dig_en_n, 8'hFF);
        step(1'b0, 32'h0, 32'h0);
        check("edge2_seg_n", seg_n, 8'hFF);
        step(1'b0, 32'h0, 32'h0);
        check("edge3_dig_en_n", dig_en_n, 8'hFE);
        check("edge3_seg_n", seg_n, 8'hC0);

        // Directed vector table: program CTRL/DATA, sample mid-DRIVE of the slot
        for (int i = 0; i < 14; i++) begin
            do_reset();
            step(1'b1, DIG_CTRL_OFS, {16'hABCD, vecs[i].ctrl});
            step(1'b1, DIG_DATA_OFS, vecs[i].data);
            run_to(vecs[i].slot * SCAN_DIV + 5);
            check($sformatf("vec%0d_dig_en_n", i), dig_en_n, vecs[i].exp_de);
            check($sformatf("vec%0d_seg_n", i), seg_n, vecs[i].exp_seg);
        end

        // Write during DRIVE: old glyph for one more cycle, new one after that
        do_reset();
        run_to(3);
        step(1'b1, DIG_DATA_OFS, 32'h0000_0008);
        check("wr_drive_old_seg", seg_n, 8'hC0);
        step(1'b0, 32'h0, 32'h0);
        check("wr_drive_new_seg", seg_n, 8'h80);
        check("wr_drive_dig_en_n", dig_en_n, 8'hFE);

        // Write on the rollover edge: next slot already uses the new value
        do_reset();
        run_to(SCAN_DIV - 1);
        step(1'b1, DIG_DATA_OFS, 32'h0000_0030);
        run_to(SCAN_DIV + 4);
        check("rollover_dig_en_n", dig_en_n, 8'hFD);
        check("rollover_seg_n", seg_n, 8'hB0);

        // Long run: index wraps 7 -> 0 several times
        run_to(SCAN_DIV * NUM_DIGITS * 2 + 4);
        check("wrap_dig_en_n", dig_en_n, 8'hFE);

        // Async reset mid-DRIVE of slot 5, then restart showing '0'
        do_reset();
        step(1'b1, DIG_DATA_OFS, 32'h1111_1111);
        run_to(5 * SCAN_DIV + 4);
        check("pre_rst_dig_en_n", dig_en_n, 8'hDF);
        check("pre_rst_seg_n", seg_n, 8'hF9);
        rst_n = 1'b0;
        #1;
        check("async_rst_dig_en_n", dig_en_n, 8'hFF);
        check("async_rst_seg_n", seg_n, 8'hFF);
        do_reset();
        run_to(3);
        check("post_rst_dig_en_n", dig_en_n, 8'hFE);
        check("post_rst_seg_n", seg_n, 8'hC0);

        // Random bus traffic against the model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 7) == 0), $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
